// File: rtl/config_pkg.sv
// Shared configuration defaults for the FIFO slice.
package config_pkg;
  localparam int FifoQueueSize = 32;
  localparam int FifoPtrSize   = $clog2(FifoQueueSize);
endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram #(
  parameter int DataWidth = 8,
  parameter int Depth     = 32,
  localparam int AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we,
  input  logic [AddrW-1:0]     waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrW-1:0]     raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow flags.
module sync_fifo
  import config_pkg::*;
#(
  parameter int DataWidth       = 8,
  parameter int Depth           = FifoQueueSize,
  parameter int AlmostFullLevel = Depth - 4,
  localparam int PtrW           = $clog2(Depth),
  localparam int CntW           = PtrW + 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 write_enable,
  input  logic                 next,
  input  logic                 clear_errors,
  output logic [DataWidth-1:0] data,
  output logic                 have_next,
  output logic                 full,
  output logic                 almost_full,
  output logic [CntW-1:0]      count,
  output logic                 overflow,
  output logic                 underflow
);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: Depth must be a power of two >= 2");
  end
  if (AlmostFullLevel < 1 || AlmostFullLevel > Depth) begin : g_bad_afl
    $error("sync_fifo: AlmostFullLevel must be within 1..Depth");
  end

  // Handshake: write_enable and next are requests that take effect on the same
  // rising edge they are sampled high, if accepted. A pop is accepted whenever
  // the FIFO holds data; a push is accepted when not full, or when full and a
  // pop is accepted in the same cycle. Rejected requests only set sticky flags.
  logic [PtrW-1:0]      in_ptr, out_ptr;
  logic [DataWidth-1:0] ram_rdata;
  logic                 push_ok, pop_ok;

  assign have_next   = (count != '0);
  assign full        = (count == CntW'(Depth));
  assign almost_full = (count >= CntW'(AlmostFullLevel));
  assign pop_ok      = next && have_next;
  assign push_ok     = write_enable && (!full || pop_ok);
  assign data        = have_next ? ram_rdata : '0;

  fifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_ram (
    .clk_i (clk_i),
    .we    (push_ok && !reset_i),
    .waddr (in_ptr),
    .wdata (data_i),
    .raddr (out_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_ptr    <= '0;
      out_ptr   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) in_ptr  <= in_ptr + PtrW'(1);
      if (pop_ok)  out_ptr <= out_ptr + PtrW'(1);
      if (push_ok && !pop_ok)      count <= count + CntW'(1);
      else if (pop_ok && !push_ok) count <= count - CntW'(1);
      // A fresh error event outranks a clear arriving in the same cycle.
      if (write_enable && !push_ok) overflow <= 1'b1;
      else if (clear_errors)        overflow <= 1'b0;
      if (next && !have_next)       underflow <= 1'b1;
      else if (clear_errors)        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: two instances (Depth=4, Depth=8) share one stimulus stream.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       we = 1'b0, nx = 1'b0, clr = 1'b0;

  logic [7:0] d4, d8;
  logic       hn4, hn8, fl4, fl8, af4, af8, of4, of8, uf4, uf8;
  logic [2:0] cnt4;
  logic [3:0] cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DataWidth(8), .Depth(4), .AlmostFullLevel(3)) dut4 (
    .clk_i(clk), .reset_i(rst), .data_i(din), .write_enable(we), .next(nx),
    .clear_errors(clr), .data(d4), .have_next(hn4), .full(fl4),
    .almost_full(af4), .count(cnt4), .overflow(of4), .underflow(uf4)
  );

  sync_fifo #(.DataWidth(8), .Depth(8), .AlmostFullLevel(6)) dut8 (
    .clk_i(clk), .reset_i(rst), .data_i(din), .write_enable(we), .next(nx),
    .clear_errors(clr), .data(d8), .have_next(hn8), .full(fl8),
    .almost_full(af8), .count(cnt8), .overflow(of8), .underflow(uf8)
  );

  // Behavioural model: a queue per instance plus sticky flags.
  logic [7:0] exp_q4[$];
  logic [7:0] exp_q8[$];
  logic       m_of4 = 0, m_uf4 = 0, m_of8 = 0, m_uf8 = 0;
  logic       model_valid = 0;

  always @(posedge clk) begin
    logic pop, push;
    if (rst) begin
      exp_q4.delete(); exp_q8.delete();
      m_of4 = 0; m_uf4 = 0; m_of8 = 0; m_uf8 = 0;
      model_valid = 1;
    end else begin
      pop  = nx && exp_q4.size() > 0;
      push = we && (exp_q4.size() < 4 || pop);
      if (we && !push) m_of4 = 1; else if (clr) m_of4 = 0;
      if (nx && exp_q4.size() == 0) m_uf4 = 1; else if (clr) m_uf4 = 0;
      if (pop)  void'(exp_q4.pop_front());
      if (push) exp_q4.push_back(din);

      pop  = nx && exp_q8.size() > 0;
      push = we && (exp_q8.size() < 8 || pop);
      if (we && !push) m_of8 = 1; else if (clr) m_of8 = 0;
      if (nx && exp_q8.size() == 0) m_uf8 = 1; else if (clr) m_uf8 = 0;
      if (pop)  void'(exp_q8.pop_front());
      if (push) exp_q8.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: both DUTs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m4_data",  32'(d4),   (exp_q4.size() > 0) ? 32'(exp_q4[0]) : 32'd0);
      chk("m4_have",  32'(hn4),  32'(exp_q4.size() > 0));
      chk("m4_full",  32'(fl4),  32'(exp_q4.size() == 4));
      chk("m4_afull", 32'(af4),  32'(exp_q4.size() >= 3));
      chk("m4_count", 32'(cnt4), 32'(exp_q4.size()));
      chk("m4_ovf",   32'(of4),  32'(m_of4));
      chk("m4_unf",   32'(uf4),  32'(m_uf4));
      chk("m8_data",  32'(d8),   (exp_q8.size() > 0) ? 32'(exp_q8[0]) : 32'd0);
      chk("m8_have",  32'(hn8),  32'(exp_q8.size() > 0));
      chk("m8_full",  32'(fl8),  32'(exp_q8.size() == 8));
      chk("m8_afull", 32'(af8),  32'(exp_q8.size() >= 6));
      chk("m8_count", 32'(cnt8), 32'(exp_q8.size()));
      chk("m8_ovf",   32'(of8),  32'(m_of8));
      chk("m8_unf",   32'(uf8),  32'(m_uf8));
    end
  end

  // Drive one cycle of inputs, step past the edge, leave outputs settled.
  task automatic cyc(input logic w, input logic n, input logic c, input logic r,
                     input logic [7:0] d);
    we = w; nx = n; clr = c; rst = r; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d4"},  32'(d4),   0); chk({tag, "_hn4"}, 32'(hn4), 0);
    chk({tag, "_fl4"}, 32'(fl4),  0); chk({tag, "_af4"}, 32'(af4), 0);
    chk({tag, "_c4"},  32'(cnt4), 0); chk({tag, "_of4"}, 32'(of4), 0);
    chk({tag, "_uf4"}, 32'(uf4),  0);
    chk({tag, "_d8"},  32'(d8),   0); chk({tag, "_hn8"}, 32'(hn8), 0);
    chk({tag, "_c8"},  32'(cnt8), 0); chk({tag, "_af8"}, 32'(af8), 0);
    chk({tag, "_of8"}, 32'(of8),  0); chk({tag, "_uf8"}, 32'(uf8), 0);
  endtask

  logic [7:0] pop_exp [3];
  logic [7:0] wrap_exp [4];

  initial begin
    pop_exp[0] = 8'h22; pop_exp[1] = 8'h33; pop_exp[2] = 8'h00;
    wrap_exp[0] = 8'h02; wrap_exp[1] = 8'h03; wrap_exp[2] = 8'h04; wrap_exp[3] = 8'h77;

    // Reset values
    cyc(0, 0, 0, 1, 8'h00);
    chk_idle("reset");

    // Three pushes then three pops
    cyc(1, 0, 0, 0, 8'h11);
    chk("push1_data", 32'(d4), 32'h11);
    cyc(1, 0, 0, 0, 8'h22);
    cyc(1, 0, 0, 0, 8'h33);
    chk("push3_count", 32'(cnt4), 3);
    chk("push3_data", 32'(d4), 32'h11);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      chk($sformatf("pop%0d_data", i), 32'(d4), 32'(pop_exp[i]));
    end
    chk("pop_empty_have", 32'(hn4), 0);

    // Depth=4 fill, fifth push dropped, then clear
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 0, 8'(i));
      if (i == 3) chk("fill3_full", 32'(fl4), 0);
      if (i == 4) chk("fill4_full", 32'(fl4), 1);
    end
    chk("ovf_set", 32'(of4), 1);
    chk("ovf_count", 32'(cnt4), 4);
    chk("ovf_head", 32'(d4), 32'h01);
    chk("ovf_d8_count", 32'(cnt8), 5);
    cyc(0, 0, 1, 0, 8'h00);
    chk("ovf_cleared", 32'(of4), 0);

    // Full FIFO: simultaneous push 0x77 and pop across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 0, 8'h77);
      chk($sformatf("wrap%0d_data", i), 32'(d4), 32'(wrap_exp[i]));
      chk($sformatf("wrap%0d_count", i), 32'(cnt4), 4);
      chk($sformatf("wrap%0d_ovf", i), 32'(of4), 0);
    end

    // Reset mid-stream with push and pop requested
    cyc(1, 1, 0, 1, 8'hEE);
    chk_idle("midrst");

    // Underflow on empty, then push+pop on empty
    cyc(0, 1, 0, 0, 8'h00);
    chk("unf_set", 32'(uf4), 1);
    chk("unf_count", 32'(cnt4), 0);
    cyc(1, 1, 0, 0, 8'hA5);
    chk("unf_push_count", 32'(cnt4), 1);
    chk("unf_push_data", 32'(d4), 32'hA5);
    chk("unf_push_flag", 32'(uf4), 1);
    cyc(0, 0, 1, 0, 8'h00);
    chk("unf_cleared", 32'(uf4), 0);
    cyc(0, 1, 1, 0, 8'h00);

    // Depth=8 almost_full threshold at 6
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 0, 0, 8'(8'h40 + i));
      if (i == 5) chk("af_at5", 32'(af8), 0);
    end
    chk("af_at6", 32'(af8), 1);
    chk("af_cnt6", 32'(cnt8), 6);
    cyc(0, 1, 0, 0, 8'h00);
    chk("af_pop5", 32'(af8), 0);
    chk("af_cnt5", 32'(cnt8), 5);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0),
          8'($urandom_range(0, 255)));
    end
    cyc(0, 0, 0, 0, 8'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DataWidth, default 8, entry width in bits.
REQ-002 SHALL have parameter Depth, default config_pkg::FifoQueueSize (32), entry count; power of two, >= 2.
REQ-003 SHALL have parameter AlmostFullLevel, default Depth-4, count at or above which almost_full asserts; range 1..Depth.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_i  input  DataWidth  write data.
REQ-007 SHALL have port write_enable  input  1  push request.
REQ-008 SHALL have port next  input  1  pop request (consume head entry).
REQ-009 SHALL have port clear_errors  input  1  clears sticky error flags.
REQ-010 SHALL have port data  output  DataWidth  head entry, first-word-fall-through.
REQ-011 SHALL have port have_next  output  1  FIFO non-empty.
REQ-012 SHALL have port full  output  1  count == Depth.
REQ-013 SHALL have port almost_full  output  1  count >= AlmostFullLevel.
REQ-014 SHALL have port count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
REQ-015 SHALL have port overflow  output  1  sticky: push was dropped.
REQ-016 SHALL have port underflow  output  1  sticky: pop was ignored.

Function
REQ-017 Pointers in_ptr/out_ptr SHALL be $clog2(Depth) bits, wrap Depth-1 -> 0 naturally; count SHALL be held in a separate register.
REQ-018 have_next, full, almost_full SHALL be combinational decodes of the count register (no extra cycle of lag).
REQ-019 data SHALL equal the entry at out_ptr when have_next=1 and SHALL be 0 when have_next=0.
REQ-020 Push accepted iff write_enable=1 and (full=0 or next=1 with have_next=1); accepted push stores data_i at in_ptr, increments in_ptr.
REQ-021 Pop accepted iff next=1 and have_next=1; accepted pop increments out_ptr.
REQ-022 count SHALL update: +1 push only, -1 pop only, unchanged when both or neither accepted.
REQ-023 Written entry SHALL be visible on data the cycle after the push (latency 1); pop SHALL present the following entry the cycle after.
REQ-024 Push while full without accepted pop SHALL be dropped, storage/pointers unchanged, overflow set to 1 next cycle.
REQ-025 Pop while empty SHALL be ignored and set underflow to 1, including when coincident with a push (push still accepted, count becomes 1).
REQ-026 Push and pop while full SHALL both be accepted; count stays Depth, no overflow.
REQ-027 clear_errors=1 SHALL clear overflow/underflow next cycle unless a new error event of that kind occurs in the same cycle, which SHALL win.

Reset
REQ-028 reset_i=1 SHALL set in_ptr=0, out_ptr=0, count=0, overflow=0, underflow=0 at the next edge, overriding all other inputs and aborting any in-flight push/pop.
REQ-029 After reset outputs SHALL be: data=0, have_next=0, full=0, almost_full=0, count=0, overflow=0, underflow=0.
REQ-030 Storage array SHALL NOT be reset; REQ-019 masks stale content.

Structure
REQ-031 FifoQueueSize and FifoPtrSize defaults SHALL live in config_pkg; pointer/count widths SHALL be derived localparams from Depth, not package constants.
REQ-032 Storage SHALL be one sub-module fifo_ram (Depth x DataWidth, one synchronous write port, one asynchronous read port); control logic stays in sync_fifo.
REQ-033 Parameter legality (power-of-two Depth, AlmostFullLevel range) SHALL be checked with elaboration-time assertions.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count=3, data=0x11; three pops -> data 0x22, 0x33, then have_next=0, data=0.
REQ-035 Depth=4: push 5 entries without pop -> full=1 after 4th, 5th dropped, overflow=1, count=4; clear_errors -> overflow=0.
REQ-036 Empty FIFO, pulse next -> underflow=1, count=0; same cycle push 0xA5 + next -> count=1, data=0xA5, underflow=1.
REQ-037 Full FIFO, simultaneous push 0x77 and pop for Depth cycles -> count stays Depth, no overflow, read order preserved across pointer wrap.
REQ-038 Depth=8, AlmostFullLevel=6: fill -> almost_full rises when count reaches 6, falls after pop to 5.
REQ-039 Assert reset_i mid-stream with write_enable and next high -> next cycle all outputs at REQ-029 values.
